// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the byte-addressed on-chip RAM.
//   ADDR_W / DATA_W : bus widths (32-bit address and data)
//   size_e          : access size encoding carried on req_size
//   state_e         : controller FSM states
//   lane_mask()     : byte-lane enables for a given size and byte lane
package mem_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_BAD  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   // Lanes touched by an access; assumes alignment was already checked.
   function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] lane);
      logic [3:0] m;
      case (size)
         SIZE_BYTE: m = 4'b0001 << lane;
         SIZE_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
         default:   m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: DEPTH_WORDS x 32-bit storage with per-byte write enables.
// Synchronous write, registered read, no reset (contents survive rst).
//   clk   : clock
//   we    : write strobe, be[3:0] selects byte lanes, wdata lane-aligned
//   re    : read strobe, rdata holds the addressed word from the next edge on
//   addr  : word index
module mem_byte_array #(
   parameter int unsigned DEPTH_WORDS = 16384,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/byte_ram_ctrl.sv
// byte_ram_ctrl: byte-addressed little-endian RAM with valid/ready request
// and response handshakes, one access outstanding, configurable wait states,
// range decode and alignment error reporting.
//   clk, rst                     : clock, asynchronous active-high reset
//   req_valid/req_ready          : request handshake
//   req_write/addr/size/wdata    : access descriptor (wdata right-justified)
//   rsp_valid/rsp_ready          : response handshake
//   rsp_rdata                    : read data, right-justified, zero-extended
//   rsp_err                      : access rejected
// Build option: define MEM_WRITE_PROTECT_EN to reject writes to the first
// WP_BYTES bytes of the region (reads there still succeed).
module byte_ram_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 16384,
   parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned WP_BYTES    = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;
   localparam logic [32:0] WP_LIMIT  = 33'(WP_BYTES);
   localparam logic [3:0]  WS        = 4'(WAIT_STATES);
`ifdef MEM_WRITE_PROTECT_EN
   localparam bit WP_ON = 1'b1;
`else
   localparam bit WP_ON = 1'b0;
`endif

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   size_e       size_q, size_d;

   logic [31:0]   offset;
   logic [1:0]    lane;
   logic [AW-1:0] word_idx;
   logic          acc_err;
   logic          commit;
   logic          mem_we, mem_re;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata, mem_rdata;
   logic [31:0]   rd_shift, rd_mask;

   // Decode of the latched request.
   always_comb begin
      offset   = addr_q - BASE_ADDR;
      lane     = offset[1:0];
      word_idx = offset[AW+1:2];
      acc_err  = 1'b0;
      if (size_q == SIZE_BAD) acc_err = 1'b1;
      if (size_q == SIZE_HALF && offset[0]) acc_err = 1'b1;
      if (size_q == SIZE_WORD && offset[1:0] != 2'b00) acc_err = 1'b1;
      // offset wraps to a huge value below BASE_ADDR, so one compare covers both ends.
      if ({1'b0, offset} >= MEM_BYTES) acc_err = 1'b1;
      if (WP_ON && wr_q && ({1'b0, offset} < WP_LIMIT)) acc_err = 1'b1;
   end

   // Lane steering for writes: replicate right-justified data into every lane.
   always_comb begin
      mem_be = lane_mask(size_q, lane);
      case (size_q)
         SIZE_BYTE: mem_wdata = {4{wdata_q[7:0]}};
         SIZE_HALF: mem_wdata = {2{wdata_q[15:0]}};
         default:   mem_wdata = wdata_q;
      endcase
   end

   assign commit = (state_q == WAIT) && (cnt_q == 4'd0);
   assign mem_we = commit && wr_q && !acc_err;
   assign mem_re = commit && !wr_q && !acc_err;

   mem_byte_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .be    (mem_be),
      .re    (mem_re),
      .addr  (word_idx),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   // WAIT always lasts at least one cycle: the latched address drives the
   // array during it and the registered read lands on the edge into RESP,
   // so the counter is preloaded with WAIT_STATES rather than WAIT_STATES-1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      size_d  = size_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               wr_d    = req_write;
               addr_d  = req_addr;
               size_d  = size_e'(req_size);
               wdata_d = req_wdata;
               cnt_d   = WS;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         size_q  <= SIZE_BYTE;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         wdata_q <= wdata_d;
      end
   end

   // Read return: shift the addressed lane down, then mask to the access size.
   always_comb begin
      rd_shift = mem_rdata >> {lane, 3'b000};
      case (size_q)
         SIZE_BYTE: rd_mask = 32'h0000_00FF;
         SIZE_HALF: rd_mask = 32'h0000_FFFF;
         default:   rd_mask = 32'hFFFF_FFFF;
      endcase
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_err   = rsp_valid && acc_err;
   assign rsp_rdata = (rsp_valid && !wr_q && !acc_err) ? (rd_shift & rd_mask) : '0;

endmodule
